// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the 9-bit CPU: owns pc and ir and holds the core on the dmem handshake.
// Optional retired-instruction counter is built when PC_SEQ_PERF_EN is defined.
module pc_sequencer #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    input  logic [8:0]      instr,
    input  logic            done_i,
    input  logic            mem_req_i,
    input  logic            br_take,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc,
    output logic [8:0]      ir,
    output logic            instr_valid,
    output logic            dmem_req,
    input  logic            dmem_ack,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     retire_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0] state;
    logic       launch;

    assign launch = start && (state == S_IDLE || state == S_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            dmem_req <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (launch) begin
                        pc    <= start_addr;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= instr;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // done outranks a memory op, which outranks any branch
                    if (done_i) begin
                        state <= S_HALT;
                    end else if (mem_req_i) begin
                        dmem_req <= 1'b1;
                        state    <= S_MEM;
                    end else begin
                        pc    <= br_take ? br_target : pc + PC_W'(1);
                        state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        pc       <= pc + PC_W'(1);
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign instr_valid = (state == S_EXEC);
    assign busy        = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign halted      = (state == S_HALT);

`ifdef PC_SEQ_PERF_EN
    logic        retire;
    logic [15:0] cnt;

    assign retire = (state == S_EXEC && !done_i && !mem_req_i) ||
                    (state == S_MEM && dmem_ack);

    always_ff @(posedge clk) begin
        if (reset || launch) begin
            cnt <= '0;
        end else if (retire && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign retire_cnt = cnt;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with a scoreboard queue of expected post-edge outputs.
// Decoder indications are driven per vector; ROM data is a fixed function of the address.
module tb_pc_sequencer;

    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            reset, start, done_i, mem_req_i, br_take, dmem_ack;
    logic [PC_W-1:0] start_addr, br_target;
    logic [8:0]      instr;
    logic [PC_W-1:0] pc;
    logic [8:0]      ir;
    logic            instr_valid, dmem_req, busy, halted;
    logic [15:0]     retire_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [8:0] rom_fn(input logic [PC_W-1:0] a);
        return a[8:0] ^ 9'h0A5 ^ {a[9], 8'h00};
    endfunction

    assign instr = rom_fn(pc);

    pc_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .instr(instr), .done_i(done_i), .mem_req_i(mem_req_i), .br_take(br_take),
        .br_target(br_target), .pc(pc), .ir(ir), .instr_valid(instr_valid),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .busy(busy), .halted(halted),
        .retire_cnt(retire_cnt)
    );

    typedef struct {
        logic            rst, st;
        logic [PC_W-1:0] saddr;
        logic            dn, mr, bt;
        logic [PC_W-1:0] tgt;
        logic            ack;
        logic [PC_W-1:0] epc;
        logic [3:0]      eflags; // {instr_valid, dmem_req, busy, halted}
        logic [15:0]     eret;
    } vec_t;

    vec_t vt[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic rst, input logic st, input logic [PC_W-1:0] saddr,
                                input logic dn, input logic mr, input logic bt,
                                input logic [PC_W-1:0] tgt, input logic ack,
                                input logic [PC_W-1:0] epc, input logic [3:0] ef,
                                input logic [15:0] er);
        vec_t v;
        v.rst = rst; v.st = st; v.saddr = saddr; v.dn = dn; v.mr = mr; v.bt = bt;
        v.tgt = tgt; v.ack = ack; v.epc = epc; v.eflags = ef;
`ifdef PC_SEQ_PERF_EN
        v.eret = er;
`else
        v.eret = 16'h0000 & er;
`endif
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v, e;
        int   n, hi;
        bit   fell;

        reset = 1'b1; start = 1'b0; start_addr = '0; done_i = 1'b0; mem_req_i = 1'b0;
        br_take = 1'b0; br_target = '0; dmem_ack = 1'b0;

        //            rst st saddr   dn mr bt tgt    ack  epc     flags    ret
        vt.push_back(mk(1, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000, 4'b0000, 0));
        // three plain instructions then done
        vt.push_back(mk(0, 1, 10'h010, 0, 0, 0, 10'h000, 0, 10'h010, 4'b0010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h010, 4'b1010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h011, 4'b0010, 1));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h011, 4'b1010, 1));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h012, 4'b0010, 2));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h012, 4'b1010, 2));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h013, 4'b0010, 3));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h013, 4'b1010, 3));
        vt.push_back(mk(0, 0, 10'h000, 1, 0, 0, 10'h000, 0, 10'h013, 4'b0001, 3));
        // load at 0x020, 4 MEM cycles without ack; start and ack in EXEC ignored
        vt.push_back(mk(0, 1, 10'h020, 0, 0, 0, 10'h000, 0, 10'h020, 4'b0010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h020, 4'b1010, 0));
        vt.push_back(mk(0, 1, 10'h3FF, 0, 1, 0, 10'h000, 1, 10'h020, 4'b0110, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h020, 4'b0110, 0));
        vt.push_back(mk(0, 1, 10'h100, 0, 0, 0, 10'h000, 0, 10'h020, 4'b0110, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h020, 4'b0110, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h020, 4'b0110, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 10'h021, 4'b0010, 1));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h021, 4'b1010, 1));
        vt.push_back(mk(0, 0, 10'h000, 1, 0, 0, 10'h000, 0, 10'h021, 4'b0001, 1));
        // taken branch at 0x005
        vt.push_back(mk(0, 1, 10'h005, 0, 0, 0, 10'h000, 0, 10'h005, 4'b0010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h005, 4'b1010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 1, 10'h3F0, 0, 10'h3F0, 4'b0010, 1));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h3F0, 4'b1010, 1));
        vt.push_back(mk(0, 0, 10'h000, 1, 0, 0, 10'h000, 0, 10'h3F0, 4'b0001, 1));
        // not-taken branch at 0x005
        vt.push_back(mk(0, 1, 10'h005, 0, 0, 0, 10'h000, 0, 10'h005, 4'b0010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h005, 4'b1010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h3F0, 0, 10'h006, 4'b0010, 1));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h006, 4'b1010, 1));
        vt.push_back(mk(0, 0, 10'h000, 1, 0, 0, 10'h000, 0, 10'h006, 4'b0001, 1));
        // pc wrap from 0x3FF
        vt.push_back(mk(0, 1, 10'h3FF, 0, 0, 0, 10'h000, 0, 10'h3FF, 4'b0010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h3FF, 4'b1010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000, 4'b0010, 1));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000, 4'b1010, 1));
        // done, mem and branch together: done wins
        vt.push_back(mk(0, 0, 10'h000, 1, 1, 1, 10'h155, 0, 10'h000, 4'b0001, 1));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 10'h000, 4'b0001, 1));
        // reset while MEM holds dmem_req
        vt.push_back(mk(0, 1, 10'h020, 0, 0, 0, 10'h000, 0, 10'h020, 4'b0010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h020, 4'b1010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 1, 0, 10'h000, 0, 10'h020, 4'b0110, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h020, 4'b0110, 0));
        vt.push_back(mk(1, 1, 10'h3FF, 0, 0, 0, 10'h000, 1, 10'h000, 4'b0000, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000, 4'b0000, 0));
        // restart; start pulses while busy do nothing
        vt.push_back(mk(0, 1, 10'h010, 0, 0, 0, 10'h000, 0, 10'h010, 4'b0010, 0));
        vt.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h010, 4'b1010, 0));
        vt.push_back(mk(0, 1, 10'h200, 0, 0, 0, 10'h000, 0, 10'h011, 4'b0010, 1));
        vt.push_back(mk(0, 1, 10'h200, 0, 0, 0, 10'h000, 0, 10'h011, 4'b1010, 1));
        vt.push_back(mk(0, 0, 10'h000, 1, 0, 0, 10'h000, 0, 10'h011, 4'b0001, 1));

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            reset = v.rst; start = v.st; start_addr = v.saddr; done_i = v.dn;
            mem_req_i = v.mr; br_take = v.bt; br_target = v.tgt; dmem_ack = v.ack;
            exp_q.push_back(v);
            tick();
            e = exp_q.pop_front();
            chk($sformatf("pc[%0d]", i), 32'(pc), 32'(e.epc));
            chk($sformatf("flags[%0d]", i), {28'd0, instr_valid, dmem_req, busy, halted},
                {28'd0, e.eflags});
            chk($sformatf("retire[%0d]", i), 32'(retire_cnt), 32'(e.eret));
            if (e.rst)
                chk($sformatf("ir_rst[%0d]", i), 32'(ir), 32'd0);
            else if (e.eflags[3])
                chk($sformatf("ir[%0d]", i), 32'(ir), 32'(rom_fn(e.epc)));
        end

        // random-length MEM stall from 0x040: dmem_req must stay high for N+1 cycles
        n = $urandom_range(1, 6);
        reset = 1'b0; start = 1'b1; start_addr = 10'h040; done_i = 1'b0;
        mem_req_i = 1'b0; br_take = 1'b0; dmem_ack = 1'b0;
        tick();
        start = 1'b0;
        tick();
        mem_req_i = 1'b1;
        tick();
        mem_req_i = 1'b0;
        hi = 0;
        fell = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!dmem_req) begin
                fell = 1'b1;
                break;
            end
            hi++;
            chk("stall_pc", 32'(pc), 32'h040);
            dmem_ack = (hi > n);
            tick();
        end
        dmem_ack = 1'b0;
        chk("stall_dmem_req_fell", 32'(fell), 32'd1);
        chk("stall_req_cycles", 32'(hi), 32'(n + 1));
        chk("stall_next_pc", 32'(pc), 32'h041);
        chk("stall_fetch", {30'd0, busy, instr_valid}, 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/execute sequencer for the 9-bit CPU. It owns the program counter and the instruction register, and presents one latched instruction per execute slot to the combinational instruction decoder. It consumes the decoder's done/load/store indications and the datapath's branch resolution, and holds the core on a data-memory request/acknowledge handshake. It sits between instruction ROM, decoder, and data memory.

## Interface
- PC_W, 10, program counter width; ROM depth is 2^PC_W.
- clk  in  1  core clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- start  in  1  launch request; honoured only in IDLE or HALT.
- start_addr  in  PC_W  first PC loaded on an accepted start.
- instr  in  9  instruction ROM data at address pc (combinational ROM).
- done_i  in  1  decoder done; valid only while instr_valid=1.
- mem_req_i  in  1  decoder loadEn|storEn; valid only while instr_valid=1.
- br_take  in  1  datapath branch/jump/ljp taken; valid only while instr_valid=1.
- br_target  in  PC_W  taken target.
- pc  out  PC_W  current program counter (ROM address).
- ir  out  9  latched instruction driving the decoder.
- instr_valid  out  1  high exactly in EXEC; decoder outputs are acted on only then.
- dmem_req  out  1  data-memory request, registered.
- dmem_ack  in  1  data-memory completion; sampled only in MEM.
- busy  out  1  high in FETCH, EXEC, MEM.
- halted  out  1  high in HALT.
- retire_cnt  out  16  retired-instruction count (see Configuration).

## Operation
- States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE: if start, set pc<=start_addr, clear retire_cnt, and go to FETCH. Otherwise stay.
- FETCH: ir<=instr, then go to EXEC.
- EXEC: priority is done_i > mem_req_i > branch.
  - done_i: go to HALT; pc is unchanged; the instruction is not retired.
  - mem_req_i: dmem_req<=1, then go to MEM; pc is unchanged.
  - Otherwise pc<= br_take ? br_target : pc+1, retire, and go to FETCH.
- MEM: hold dmem_req=1 until dmem_ack.
  - On ack: dmem_req<=0, pc<=pc+1, retire, and go to FETCH.
  - No timeout; the sequencer stalls indefinitely.
- HALT: if start, behave as in IDLE (reload pc, clear counter, go to FETCH).
- pc+1 wraps modulo 2^PC_W (all ones -> 0).
- start is ignored in FETCH, EXEC, and MEM.
- br_take is ignored when done_i or mem_req_i is also high.
- dmem_ack outside MEM is ignored.

## Timing
- Reset values: state=IDLE, pc=0, ir=0, instr_valid=0, dmem_req=0, busy=0, halted=0, retire_cnt=0.
- Reset mid-operation, including MEM with dmem_req high, returns to the reset state on the next edge. dmem_req drops immediately and no retire is counted.
- start to first instr_valid: 2 cycles (IDLE→FETCH→EXEC).
- Non-memory instruction: 2 cycles per instruction (FETCH, EXEC).
- Memory instruction: 3+N cycles, where N is the number of MEM cycles with dmem_ack=0. An ack in the first MEM cycle gives FETCH on the next edge.
- dmem_req rises on the edge leaving EXEC and falls on the edge after the ack is sampled.
- halted rises the cycle after the EXEC in which done_i is sampled.

## Configuration
- PC_SEQ_PERF_EN defined:
  - retire_cnt increments by 1 on each retire and saturates at 16'hFFFF.
  - It clears on reset and on each accepted start.
- PC_SEQ_PERF_EN undefined: retire_cnt is tied to 0 and no counter logic is present.
- The port exists in both builds.

## Test plan
- Reset, then start with start_addr=0x010 and a ROM of three non-memory, non-branch instructions followed by a done instruction. Required: pc sequence 0x010, 0x011, 0x012, 0x013; halted high at cycle 9 after start; retire_cnt=3 (PERF build).
- Load at 0x020, with dmem_ack held low for 4 MEM cycles. Required: dmem_req high for exactly 5 cycles; pc stays 0x020 throughout; FETCH of 0x021 follows.
- Branch with br_take=1, br_target=0x3F0 at pc 0x005. Required: next pc=0x3F0. Repeat with br_take=0: next pc=0x006.
- pc=0x3FF, non-memory instruction, br_take=0. Required: pc wraps to 0x000.
- In a single EXEC cycle, assert done_i=1, mem_req_i=1, br_take=1. Required: HALT, dmem_req stays 0, pc unchanged, no retire.
- Assert reset during MEM with dmem_req=1. Required: next cycle all outputs at reset values. A later start behaves normally; start pulses asserted while busy have no effect.
